gpr_arbiter: RTL
================

GPR_ARBITER -- requirements
Module: gpr_arbiter

Interface
REQ-001 Parameters: N, 32, data width; Nreg, 32, register count; K, $clog2(Nreg), address width; M, 4, number of requesters (M>=2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low.
REQ-004 Port: req  input  M  per-requester access request; held high until granted.
REQ-005 Port: we  input  M  per-requester write enable; meaningful only while req[i]=1.
REQ-006 Port: lock  input  M  per-requester lock request; meaningful only while req[i]=1.
REQ-007 Port: addr  input  M*K  packed register addresses; requester i occupies bits [i*K +: K].
REQ-008 Port: wdata  input  M*N  packed write data; requester i occupies bits [i*N +: N].
REQ-009 Port: gnt  output  M  one-hot grant; combinational, same cycle as the accepted req.
REQ-010 Port: rvalid  output  M  one-hot response strobe; one-cycle pulse per grant.
REQ-011 Port: rdata  output  N  response data shared by all requesters; qualified by rvalid.
REQ-012 Port: gpr_address  output  K  register-file address; registered.
REQ-013 Port: gpr_d  output  N  register-file write data; registered.
REQ-014 Port: gpr_wren  output  1  register-file write enable; registered.
REQ-015 Port: gpr_q  input  N  register-file read data; combinational from gpr_address.

Function
REQ-016 At most one gnt bit shall be high per cycle; gnt[i] high requires req[i]=1 in the same cycle.
REQ-017 In state ARB, the winner shall be the first requesting index at or after rr_ptr, scanning upward modulo M.
REQ-018 On every grant to i, rr_ptr shall load (i+1) mod M; with no grant, rr_ptr shall hold.
REQ-019 Grant in cycle T shall capture addr[i], wdata[i], we[i] and i into the access stage.
REQ-020 Cycle T+1: gpr_address = captured addr; gpr_d = captured wdata; gpr_wren = captured we AND (addr != 0).
REQ-021 With no grant in T, gpr_wren shall be 0 in T+1; gpr_address and gpr_d shall hold their previous values.
REQ-022 End of T+1: rdata shall register gpr_q, forced to 0 when the address is 0. In T+2, rvalid[i] shall pulse high for exactly one cycle.
REQ-023 For a write, rdata shall be the pre-write (old) register value, giving an atomic swap.
REQ-024 Throughput: one grant per cycle; back-to-back grants shall pipeline with no bubble.
REQ-025 Between pulses, rdata shall hold its last value.
REQ-026 FSM states: ARB and LOCKED.
REQ-027 ARB -> LOCKED when the granted requester has lock=1; lock_owner shall record that index.
REQ-028 In LOCKED, only lock_owner shall be grantable; all other requests shall wait with gnt=0.
REQ-029 In LOCKED, a grant to lock_owner with lock=0 shall perform that access and return to ARB.
REQ-030 In LOCKED, a grant to lock_owner with lock=1 shall remain in LOCKED.
REQ-031 In LOCKED, rr_ptr shall still update per REQ-018.
REQ-032 In LOCKED, if lock_owner deasserts req, the FSM shall remain LOCKED; there is no timeout.
REQ-033 Address 0 (MIPS $zero): writes shall be suppressed at gpr_wren, and reads shall return 0.

Reset
REQ-034 While rst=0: gnt=0 and rvalid=0 combinationally, independent of the clock.
REQ-035 While rst=0: rdata=0, gpr_address=0, gpr_d=0, gpr_wren=0, rr_ptr=0, FSM=ARB, access stage empty.
REQ-036 Reset asserted mid-operation shall discard in-flight accesses: no gpr_wren pulse and no rvalid pulse for them after release.
REQ-037 The first cycle after reset release shall arbitrate normally, starting from requester 0.

Verification
REQ-038 Single read: req[2]=1, addr=5, gpr_q=0xDEADBEEF in T+1 -> gnt[2] at T, gpr_address=5 at T+1, rvalid[2] and rdata=0xDEADBEEF at T+2.
REQ-039 Round-robin: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles; rvalid follows 2 cycles later.
REQ-040 Swap: requester 1 writes 0x55 to reg 7 holding 0x11 -> gpr_wren=1 at T+1 and rdata=0x11 at T+2; a following read of reg 7 returns 0x55.
REQ-041 Zero register: write 0xFF to addr 0 -> gpr_wren=0 and rdata=0 with rvalid pulse.
REQ-042 Lock: requester 0 locks while req=4'b1111 for 3 cycles, then lock=0 on the 4th -> gnt=0001 for 4 cycles, then requester 1 is granted.
REQ-043 Reset mid-pipeline: rst=0 in the cycle after a write grant -> no gpr_wren and no rvalid; all outputs 0 after release.

Source files
------------

// File: rtl/gpr_arbiter.sv
// Round-robin arbiter with lock support in front of a single-port GPR file.
// Each grant does one read-modify-write: write at T+1 and return the old value at T+2.
module gpr_arbiter #(
    parameter int N    = 32,
    parameter int Nreg = 32,
    parameter int K    = $clog2(Nreg),
    parameter int M    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req,
    input  logic [M-1:0]   we,
    input  logic [M-1:0]   lock,
    input  logic [M*K-1:0] addr,
    input  logic [M*N-1:0] wdata,
    output logic [M-1:0]   gnt,
    output logic [M-1:0]   rvalid,
    output logic [N-1:0]   rdata,
    output logic [K-1:0]   gpr_address,
    output logic [N-1:0]   gpr_d,
    output logic           gpr_wren,
    input  logic [N-1:0]   gpr_q
);

    localparam int PW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   lock_owner;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   next_ptr;
    logic [M-1:0]    win_onehot;
    logic [K-1:0]    win_addr;
    logic [N-1:0]    win_wdata;
    logic            win_we;
    logic            win_lock;

    // Requester whose access is on the GPR port this cycle (one-hot, zero when idle).
    logic [M-1:0]    acc_onehot;
    logic [M-1:0]    rvalid_q;

    always_comb begin
        int cand;
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (state == LOCKED) begin
            win_found = req[lock_owner];
            win_idx   = lock_owner;
        end else begin
            for (int k = 0; k < M; k++) begin
                cand = (int'(rr_ptr) + k) % M;
                if (!win_found && req[PW'(cand)]) begin
                    win_found = 1'b1;
                    win_idx   = PW'(cand);
                end
            end
        end
    end

    assign win_onehot = M'(1) << win_idx;
    assign win_addr   = addr[int'(win_idx)*K +: K];
    assign win_wdata  = wdata[int'(win_idx)*N +: N];
    assign win_we     = we[win_idx];
    assign win_lock   = lock[win_idx];
    assign next_ptr   = (int'(win_idx) == M - 1) ? '0 : win_idx + 1'b1;

    // Grant and response strobes are cut off by reset without waiting for a clock edge.
    assign gnt    = (rst && win_found) ? win_onehot : '0;
    assign rvalid = rst ? rvalid_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            lock_owner <= '0;
        end else if (win_found) begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            rr_ptr <= next_ptr;
            case (state)
                ARB: begin
                    if (win_lock) begin
                        state      <= LOCKED;
                        lock_owner <= win_idx;
                    end
                end
                LOCKED: begin
                    if (!win_lock) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr_address <= '0;
            gpr_d       <= '0;
            gpr_wren    <= 1'b0;
            acc_onehot  <= '0;
            rvalid_q    <= '0;
            rdata       <= '0;
        end else begin
            gpr_wren   <= win_found && win_we && (win_addr != '0);
            acc_onehot <= win_found ? win_onehot : '0;
            if (win_found) begin
                gpr_address <= win_addr;
                gpr_d       <= win_wdata;
            end
            // gpr_q still shows the pre-write value here, which makes each write a swap.
            rvalid_q <= acc_onehot;
            if (|acc_onehot) begin
                rdata <= (gpr_address == '0) ? '0 : gpr_q;
            end
        end
    end

endmodule
